demux_4bit_1to2_stream: RTL and testbench



---
 rtl/demux_4bit_1to2_stream_pkg.sv | 13 +
 rtl/stream_fifo_sync.sv | 79 +++++++
 rtl/demux_4bit_1to2_stream.sv | 80 ++++++++
 tb/tb_demux_4bit_1to2_stream.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_4bit_1to2_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
//   DEF_WIDTH / DEF_DEPTH / DEF_CNT_W : default data width, FIFO depth, counter width
//   SEL_OUT0 / SEL_OUT1               : in_sel encodings that pick output 0 / output 1
package demux_defs;

    localparam int   DEF_WIDTH = 4;
    localparam int   DEF_DEPTH = 2;
    localparam int   DEF_CNT_W = 8;

    localparam logic SEL_OUT0  = 1'b0;
    localparam logic SEL_OUT1  = 1'b1;

endpackage

// File: rtl/stream_fifo_sync.sv
// Small synchronous FIFO used as the buffer behind each demux output.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data (ignored while full)
//   pop        : drop the head (ignored while empty)
//   head_data  : oldest entry; when empty, the last value popped (0 after reset)
//   full/empty : occupancy == DEPTH / occupancy == 0
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module stream_fifo_sync #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int          PW       = $clog2(DEPTH);
    localparam int          OW       = PW + 1;
    localparam logic [PW:0] FULL_OCC = OW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]                 occ_q, occ_d;
    logic [WIDTH-1:0]            last_q, last_d;
    logic                        do_push, do_pop;

    assign full    = (occ_q == FULL_OCC);
    assign empty   = (occ_q == '0);
    // No full-bypass: a full FIFO refuses a write even if it pops this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Hold the last popped value on the head while empty so the output bus
    // does not show stale, already-consumed storage.
    assign head_data = empty ? last_q : mem_q[rd_q];

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        occ_d  = occ_q;
        last_d = last_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PW'(1);
        end
        if (do_pop) begin
            last_d = mem_q[rd_q];
            rd_d   = rd_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            occ_q  <= '0;
            last_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            occ_q  <= occ_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/demux_4bit_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer with per-output transfer counters.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_data/in_sel/in_valid   : input beat, destination select, producer valid
//   in_ready                  : beat accepted this cycle (depends on in_sel, never on in_valid)
//   outN_data/outN_valid      : head of output FIFO N / FIFO N non-empty
//   outN_ready                : consumer N takes the head
//   cnt0/cnt1                 : completed output transfers, wrapping counters
module demux_4bit_1to2_stream
    import demux_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int                 NUM_OUT  = 2;
    localparam logic [NUM_OUT-1:0] LANE_SEL = {SEL_OUT1, SEL_OUT0};

    logic [NUM_OUT-1:0]            push, pop, full, empty, out_ready;
    logic [NUM_OUT-1:0][WIDTH-1:0] head;
    logic [NUM_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                          in_fire;

    assign out_ready = {out1_ready, out0_ready};

    // Gated by rst_n so the producer sees no acceptance while reset is held.
    assign in_ready = rst_n & ~full[in_sel];
    assign in_fire  = in_valid & in_ready;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign push[g]  = in_fire & (in_sel == LANE_SEL[g]);
        assign pop[g]   = out_ready[g] & ~empty[g];
        assign cnt_d[g] = pop[g] ? cnt_q[g] + CNT_W'(1) : cnt_q[g];

        stream_fifo_sync #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .push_data (in_data),
            .pop       (pop[g]),
            .head_data (head[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign cnt0       = cnt_q[0];
    assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux_4bit_1to2_stream.sv
module tb_demux_4bit_1to2_stream;

    localparam int W  = 4;
    localparam int D  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out0_data, out1_data;
    logic          out0_valid, out1_valid;
    logic          out0_ready = 1'b0, out1_ready = 1'b0;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    demux_4bit_1to2_stream #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    int checks = 0;
    int failures = 0;

    // Scoreboard: beats pushed at acceptance, popped when the DUT delivers them.
    logic [W-1:0]  q0[$];
    logic [W-1:0]  q1[$];
    logic [CW-1:0] m_cnt0 = '0, m_cnt1 = '0;

    typedef struct {
        logic         v, sel;
        logic [W-1:0] d;
        logic         r0, r1;
        logic         e_rdy, e_v0, e_v1;
        logic [W-1:0] e_d0, e_d1;
        logic [CW-1:0] e_c0, e_c1;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic sel, input logic [W-1:0] d,
                                input logic r0, input logic r1, input logic e_rdy,
                                input logic e_v0, input logic e_v1,
                                input logic [W-1:0] e_d0, input logic [W-1:0] e_d1,
                                input logic [CW-1:0] e_c0, input logic [CW-1:0] e_c1);
        vec_t t;
        t.v = v; t.sel = sel; t.d = d; t.r0 = r0; t.r1 = r1;
        t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_v1 = e_v1;
        t.e_d0 = e_d0; t.e_d1 = e_d1; t.e_c0 = e_c0; t.e_c1 = e_c1;
        return t;
    endfunction

    // Monitor: values at the falling edge are the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mon_in_ready", int'(in_ready), int'((in_sel ? q1.size() : q0.size()) < D));
            check("mon_v0", int'(out0_valid), int'(q0.size() > 0));
            check("mon_v1", int'(out1_valid), int'(q1.size() > 0));
            check("mon_cnt0", int'(cnt0), int'(m_cnt0));
            check("mon_cnt1", int'(cnt1), int'(m_cnt1));
            if (out0_valid && out0_ready && q0.size() > 0) begin
                check("mon_d0", int'(out0_data), int'(q0.pop_front()));
                m_cnt0++;
            end
            if (out1_valid && out1_ready && q1.size() > 0) begin
                check("mon_d1", int'(out1_data), int'(q1.pop_front()));
                m_cnt1++;
            end
            if (in_valid && in_ready) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    // Asserts reset between clock edges and checks the outputs clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_v0", int'(out0_valid), 0);
        check("rst_v1", int'(out1_valid), 0);
        check("rst_d0", int'(out0_data), 0);
        check("rst_d1", int'(out1_data), 0);
        check("rst_cnt0", int'(cnt0), 0);
        check("rst_cnt1", int'(cnt1), 0);
        check("rst_in_ready", int'(in_ready), 0);
        q0.delete(); q1.delete();
        m_cnt0 = '0; m_cnt1 = '0;
        in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_tbl(input string name);
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].d;
            out0_ready = tbl[i].r0; out1_ready = tbl[i].r1;
            @(negedge clk);
            check($sformatf("%s[%0d].rdy", name, i), int'(in_ready), int'(tbl[i].e_rdy));
            check($sformatf("%s[%0d].v0", name, i), int'(out0_valid), int'(tbl[i].e_v0));
            check($sformatf("%s[%0d].v1", name, i), int'(out1_valid), int'(tbl[i].e_v1));
            if (tbl[i].e_v0) check($sformatf("%s[%0d].d0", name, i), int'(out0_data), int'(tbl[i].e_d0));
            if (tbl[i].e_v1) check($sformatf("%s[%0d].d1", name, i), int'(out1_data), int'(tbl[i].e_d1));
            check($sformatf("%s[%0d].c0", name, i), int'(cnt0), int'(tbl[i].e_c0));
            check($sformatf("%s[%0d].c1", name, i), int'(cnt1), int'(tbl[i].e_c1));
        end
        tbl.delete();
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int sent;
        int budget;

        // Reset state while held, then idle ready for both selects.
        #3;
        check("init_v0", int'(out0_valid), 0);
        check("init_v1", int'(out1_valid), 0);
        check("init_d0", int'(out0_data), 0);
        check("init_d1", int'(out1_data), 0);
        check("init_cnt0", int'(cnt0), 0);
        check("init_cnt1", int'(cnt1), 0);
        check("init_in_ready_low", int'(in_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        in_sel = 1'b0; #1;
        check("idle_rdy_sel0", int'(in_ready), 1);
        in_sel = 1'b1; #1;
        check("idle_rdy_sel1", int'(in_ready), 1);
        in_sel = 1'b0;

        // Steering: 3 -> out0, A -> out1, 5 -> out0, readies high.
        //          v sel d      r0 r1 rdy v0 v1 d0     d1     c0 c1
        tbl.push_back(mk(1, 0, 4'h3, 1, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(mk(1, 1, 4'hA, 1, 1, 1, 1, 0, 4'h3, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h5, 1, 1, 1, 0, 1, 4'h0, 4'hA, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 0, 4'h5, 4'h0, 1, 1));
        tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0, 0, 4'h0, 4'h0, 2, 1));
        run_tbl("steer");

        // Backpressure: out0 stalled fills, third beat refused, re-steered to out1.
        do_reset();
        tbl.push_back(mk(1, 0, 4'h1, 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h2, 0, 1, 1, 1, 0, 4'h1, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h3, 0, 1, 0, 1, 0, 4'h1, 4'h0, 0, 0));
        tbl.push_back(mk(1, 1, 4'h3, 0, 1, 1, 1, 0, 4'h1, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 1, 1, 1, 1, 1, 4'h1, 4'h3, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 0, 4'h2, 4'h0, 1, 1));
        tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0, 0, 4'h0, 4'h0, 2, 1));
        run_tbl("bp");

        // Full with concurrent pop: no bypass, beat accepted the cycle after.
        do_reset();
        tbl.push_back(mk(1, 0, 4'h7, 0, 0, 1, 0, 0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h8, 0, 0, 1, 1, 0, 4'h7, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h9, 1, 0, 0, 1, 0, 4'h7, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h9, 1, 0, 1, 1, 0, 4'h8, 4'h0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 1, 0, 4'h9, 4'h0, 2, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 0, 0, 4'h0, 4'h0, 3, 0));
        run_tbl("fullpop");

        // Pointer and counter wrap: 18 beats 0..F,0,1 through output 1.
        do_reset();
        sent = 0; budget = 0;
        out1_ready = 1'b1;
        while (sent < 18 && budget < 100) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_sel = 1'b1; in_data = sent[W-1:0];
            @(negedge clk);
            if (in_ready) sent++;
            budget++;
        end
        check("wrap_sent", sent, 18);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wrap_cnt1", int'(cnt1), 2);
        check("wrap_drained", q1.size(), 0);

        // Random soak against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            in_valid   = 1'($urandom_range(0, 1));
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = W'($urandom);
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("soak_q0_empty", q0.size(), 0);
        check("soak_q1_empty", q1.size(), 0);
        check("soak_cnt0", int'(cnt0), int'(m_cnt0));
        check("soak_cnt1", int'(cnt1), int'(m_cnt1));

        // Mid-stream async reset with both FIFOs holding data.
        @(posedge clk); #1;
        out0_ready = 1'b0; out1_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = k[0]; in_data = W'(k + 4);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_v0", int'(out0_valid), 1);
        check("pre_rst_v1", int'(out1_valid), 1);
        do_reset();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
